// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: arbitrates level interrupt requests masked by MIE, raises
// irq_o with mcause_o, and pulses int_fin_o one-hot to the source on mret.
// Ports: clk_i, rst_i (async, active-high), int_req_i, mie_i, int_rst_i,
//        irq_o, mcause_o, int_fin_o; all outputs registered.
module miriscv_irq_ctrl #(
  parameter int N_SRC       = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o
);

  localparam int IW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIN
  } state_e;

  typedef logic [IW:0] idx_t;

  state_e           state_q, state_d;
  logic             irq_q, irq_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_SRC-1:0] fin_q, fin_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [N_SRC-1:0] elig;
  logic [IW-1:0]    base;
  logic [IW-1:0]    sel;
  logic             hit;
  idx_t             idx;

  assign elig = int_req_i & mie_i;
  assign base = ROUND_ROBIN ? ptr_q : '0;

  // Scan from base upward with wrap; first eligible index wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = {1'b0, base} + idx_t'(i);
      if (idx >= idx_t'(N_SRC)) begin
        idx = idx - idx_t'(N_SRC);
      end
      if (!hit && elig[idx[IW-1:0]]) begin
        hit = 1'b1;
        sel = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    mcause_d = mcause_q;
    fin_d    = '0;
    id_d     = id_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        irq_d = 1'b0;
        if (hit) begin
          id_d     = sel;
          mcause_d = {1'b1, {(31-IW){1'b0}}, sel};
          irq_d    = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (int_rst_i) begin
          irq_d   = 1'b0;
          fin_d   = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;
          state_d = S_FIN;
          if (ROUND_ROBIN) begin
            ptr_d = (id_q == IW'(N_SRC-1)) ? '0 : id_q + IW'(1);
          end
        end
      end
      S_FIN: begin
        // One quiet cycle lets the source drop its level.
        irq_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      irq_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign irq_o     = irq_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule
